// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared CSR addresses, mcause codes and FSM encodings for trap_ctrl
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] MCAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_SOFT    = 32'h8000_0003;
  localparam logic [31:0] MCAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] MCAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_W_MEPC    = 3'd1;
  localparam logic [2:0] S_W_MCAUSE  = 3'd2;
  localparam logic [2:0] S_W_MTVAL   = 3'd3;
  localparam logic [2:0] S_W_MSTATUS = 3'd4;
  localparam logic [2:0] S_JUMP      = 3'd5;
  localparam logic [2:0] S_R_MSTATUS = 3'd6;
  localparam logic [2:0] S_R_JUMP    = 3'd7;

  typedef enum logic [1:0] {ACC_NONE, ACC_TRAP, ACC_MRET} acc_e;

  // States that drive a CSR write and therefore yield to execute-stage writes.
  function automatic logic is_write_state(input logic [2:0] s);
    return (s == S_W_MEPC) || (s == S_W_MCAUSE) || (s == S_W_MTVAL) ||
           (s == S_W_MSTATUS) || (s == S_R_MSTATUS);
  endfunction

endpackage

// File: rtl/trap_arb.sv
// rtl/trap_arb.sv - combinational trap priority with cause/epc/tval selection
module trap_arb
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            hx_valid,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_next_i,
  input  logic [31:0]     inst_i,
  input  logic            exc_ecall_i,
  input  logic            exc_ebreak_i,
  input  logic            exc_illegal_i,
  input  logic            mret_i,
  input  logic            ex_trap_valid_i,
  input  logic            tcmp_trap_valid_i,
  input  logic            soft_trap_valid_i,
  input  logic            mstatus_MIE3_i,
  output acc_e            acc_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] epc_o,
  output logic [XLEN-1:0] tval_o
);

  always_comb begin
    acc_o   = ACC_NONE;
    cause_o = '0;
    epc_o   = pc_i;
    tval_o  = '0;
    if (hx_valid) begin
      if (exc_illegal_i) begin
        acc_o   = ACC_TRAP;
        cause_o = XLEN'(MCAUSE_ILLEGAL);
        tval_o  = XLEN'(inst_i);
      end else if (exc_ebreak_i) begin
        acc_o   = ACC_TRAP;
        cause_o = XLEN'(MCAUSE_EBREAK);
        tval_o  = pc_i;
      end else if (exc_ecall_i) begin
        acc_o   = ACC_TRAP;
        cause_o = XLEN'(MCAUSE_ECALL);
      end else if (mret_i) begin
        acc_o = ACC_MRET;
      end else if (mstatus_MIE3_i && ex_trap_valid_i) begin
        acc_o   = ACC_TRAP;
        cause_o = XLEN'(MCAUSE_EXT);
        epc_o   = pc_next_i;
      end else if (mstatus_MIE3_i && tcmp_trap_valid_i) begin
        acc_o   = ACC_TRAP;
        cause_o = XLEN'(MCAUSE_TIMER);
        epc_o   = pc_next_i;
      end else if (mstatus_MIE3_i && soft_trap_valid_i) begin
        acc_o   = ACC_TRAP;
        cause_o = XLEN'(MCAUSE_SOFT);
        epc_o   = pc_next_i;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry / mret sequencer driving the CSR trap channel
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hx_valid,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   pc_next_i,
  input  logic [31:0]       inst_i,
  input  logic              exc_ecall_i,
  input  logic              exc_ebreak_i,
  input  logic              exc_illegal_i,
  input  logic              mret_i,
  input  logic              ex_trap_valid_i,
  input  logic              tcmp_trap_valid_i,
  input  logic              soft_trap_valid_i,
  input  logic              mstatus_MIE3_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic              idex_csr_we_i,
  output logic              trap_csr_we_o,
  output logic [CSR_AW-1:0] trap_csr_addr_o,
  output logic [XLEN-1:0]   trap_csr_wdata_o,
  input  logic [XLEN-1:0]   trap_csr_rdata_i,
  output logic              hold_o,
  output logic              jump_flag_o,
  output logic [XLEN-1:0]   jump_addr_o
);

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;

  acc_e            w_acc;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_epc;
  logic [XLEN-1:0] w_tval;
  logic            w_write;

  trap_arb #(.XLEN(XLEN)) u_arb (
    .hx_valid          (hx_valid),
    .pc_i              (pc_i),
    .pc_next_i         (pc_next_i),
    .inst_i            (inst_i),
    .exc_ecall_i       (exc_ecall_i),
    .exc_ebreak_i      (exc_ebreak_i),
    .exc_illegal_i     (exc_illegal_i),
    .mret_i            (mret_i),
    .ex_trap_valid_i   (ex_trap_valid_i),
    .tcmp_trap_valid_i (tcmp_trap_valid_i),
    .soft_trap_valid_i (soft_trap_valid_i),
    .mstatus_MIE3_i    (mstatus_MIE3_i),
    .acc_o             (w_acc),
    .cause_o           (w_cause),
    .epc_o             (w_epc),
    .tval_o            (w_tval)
  );

  // A write state only advances on the cycle its write actually lands.
  assign w_write = is_write_state(r_state) && !idex_csr_we_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc == ACC_TRAP) begin
            r_state <= S_W_MEPC;
            r_cause <= w_cause;
            r_epc   <= w_epc;
            r_tval  <= w_tval;
          end else if (w_acc == ACC_MRET) begin
            r_state <= S_R_MSTATUS;
          end
        end
        S_W_MEPC:    if (w_write) r_state <= S_W_MCAUSE;
        S_W_MCAUSE:  if (w_write) r_state <= S_W_MTVAL;
        S_W_MTVAL:   if (w_write) r_state <= S_W_MSTATUS;
        S_W_MSTATUS: if (w_write) r_state <= S_JUMP;
        S_R_MSTATUS: if (w_write) r_state <= S_R_JUMP;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = '0;
    jump_flag_o      = 1'b0;
    jump_addr_o      = '0;
    case (r_state)
      S_W_MEPC: begin
        trap_csr_addr_o  = CSR_AW'(CSR_MEPC);
        trap_csr_wdata_o = r_epc;
      end
      S_W_MCAUSE: begin
        trap_csr_addr_o  = CSR_AW'(CSR_MCAUSE);
        trap_csr_wdata_o = r_cause;
      end
      S_W_MTVAL: begin
        trap_csr_addr_o  = CSR_AW'(CSR_MTVAL);
        trap_csr_wdata_o = r_tval;
      end
      S_W_MSTATUS: begin
        trap_csr_addr_o     = CSR_AW'(CSR_MSTATUS);
        trap_csr_wdata_o    = trap_csr_rdata_i;
        trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
        trap_csr_wdata_o[3] = 1'b0;
      end
      S_JUMP: begin
        trap_csr_addr_o = CSR_AW'(CSR_MTVEC);
        jump_flag_o     = 1'b1;
        jump_addr_o     = {trap_csr_rdata_i[XLEN-1:2], 2'b00};
      end
      S_R_MSTATUS: begin
        trap_csr_addr_o     = CSR_AW'(CSR_MSTATUS);
        trap_csr_wdata_o    = trap_csr_rdata_i;
        trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
        trap_csr_wdata_o[7] = 1'b1;
      end
      S_R_JUMP: begin
        jump_flag_o = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: ;
    endcase
    trap_csr_we_o = w_write;
  end

  assign hold_o = (r_state != S_IDLE);

endmodule
